// File: rtl/const_prod_mult_seq.sv
// const_prod_mult_seq
//   Multi-cycle shift-add engine computing result = CONST * num1 * num2.
//   Phase MUL1 forms P = num1 * num2 in WIDTH cycles, phase MUL2 forms
//   CONST * P in CONST_W cycles. The result is full precision
//   (RES_W = 2*WIDTH + CONST_W), so it can never overflow.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   num1/num2 are valid
//   in_ready   operands can be accepted this cycle
//   num1       unsigned operand A [WIDTH]
//   num2       unsigned operand B [WIDTH]
//   out_valid  result is valid and held
//   out_ready  consumer takes the result this cycle
//   result     CONST*num1*num2, unsigned [RES_W]
//   busy       high while multiplying (MUL1 or MUL2)
//   state_dbg  current FSM state (IDLE=0, MUL1=1, MUL2=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. Input side: in_ready is high in IDLE, and in DONE when the
// result is being taken in the same cycle, which lets a new operand pair
// enter MUL1 on the result's handshake edge with no bubble. Output side:
// out_valid/result stay stable from completion until out_valid & out_ready.

module const_prod_mult_seq #(
  parameter int WIDTH   = 20,
  parameter int CONST   = 7,
  parameter int CONST_W = 3,
  localparam int RES_W  = 2 * WIDTH + CONST_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // The multiplier register serves both phases, so it is as wide as the
  // wider of the two multipliers (num2 in MUL1, CONST in MUL2).
  localparam int MW    = (WIDTH > CONST_W) ? WIDTH : CONST_W;
  localparam int CNT_W = $clog2(MW + 1);

  if ((CONST < 0) || (CONST >= (1 << CONST_W))) begin : g_const_check
    $error("const_prod_mult_seq: CONST=%0d does not fit in CONST_W=%0d bits",
           CONST, CONST_W);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [RES_W-1:0] mcand;   // shifted multiplicand
  logic [MW-1:0]    mplier;  // multiplier, consumed LSB first
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [RES_W-1:0] acc_next;
  logic             accept;

  assign acc_next  = mplier[0] ? (acc + mcand) : acc;
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state == MUL1) | (state == MUL2);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // out_ready while out_valid is low is harmless: it only clears
          // a flag that is already clear.
          if (out_ready) out_valid <= 1'b0;
          if (accept) begin
            mcand  <= RES_W'(num1);
            mplier <= MW'(num2);
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL1;
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end

        MUL1: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // acc_next now holds P = num1*num2; it becomes the multiplicand.
            mcand  <= acc_next;
            mplier <= MW'(CONST);
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL2;
          end
        end

        MUL2: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(CONST_W - 1)) begin
            result    <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
